// File: rtl/dac_batch_streamer.sv
// dac_batch_streamer: FWFT batch FIFO feeding an AXI-stream DAC, primed before streaming
module dac_batch_streamer #(
  parameter int BATCH_WIDTH = 256,
  parameter int DEPTH = 8,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [BATCH_WIDTH-1:0] batch_in,
  input  logic                   batch_valid,
  output logic                   dac_rdy,
  output logic [BATCH_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   streaming,
  output logic [15:0]            underflow_cnt,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [BATCH_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] underflow_cnt_q, underflow_cnt_d;
  logic overflow_q, overflow_d;
  logic wr, pop, uf, empty;
  assign empty = count_q == '0;
  assign dac_rdy = (count_q != CW'(DEPTH)) && !flush && !rst;
  assign wr = batch_valid && dac_rdy;
  assign underflow_cnt = underflow_cnt_q;
  assign overflow = overflow_q;
  // state and FIFO bookkeeping registers; memory contents survive reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      underflow_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      underflow_cnt_q <= underflow_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  // batch storage, written only on an accepted batch
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= batch_in;
  end
  // next state: prime in IDLE, fall back to IDLE on underflow or flush
  always_comb begin
    state_d = flush ? IDLE
            : state_q == IDLE ? (count_q >= CW'(PRIME_LEVEL) ? STREAM : IDLE)
            : (m_tready && empty ? IDLE : STREAM);
  end
  // outputs: zeros unless streaming with data; valid in every non-reset cycle
  always_comb begin
    streaming = state_q == STREAM;
    pop = streaming && m_tready && !empty;
    uf = streaming && m_tready && empty;
    m_tdata = (streaming && !empty && !rst) ? mem_q[rd_ptr_q] : '0;
    m_tvalid = !rst;
  end
  // pointer, occupancy and status next values; pointers wrap since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(wr) - CW'(pop);
    underflow_cnt_d = underflow_cnt_q + 16'(uf && underflow_cnt_q != 16'hFFFF);
    overflow_d = overflow_q | (batch_valid && !dac_rdy && !flush);
  end
endmodule

// File: tb/tb_dac_batch_streamer.sv
// tb_dac_batch_streamer: directed scenario checks for dac_batch_streamer
module tb_dac_batch_streamer;
  logic clk, rst, flush, batch_valid, m_tready;
  logic [31:0] batch_in, m_tdata;
  logic dac_rdy, m_tvalid, streaming, overflow;
  logic [15:0] underflow_cnt;
  int tests = 0, fails = 0;

  dac_batch_streamer #(.BATCH_WIDTH(32), .DEPTH(8), .PRIME_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .batch_in(batch_in), .batch_valid(batch_valid),
    .dac_rdy(dac_rdy), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .streaming(streaming), .underflow_cnt(underflow_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; batch_valid = 0; batch_in = '0; m_tready = 0;
    step(); step();
    tests++; if (dac_rdy !== 1'b0) begin fails++; $display("FAIL rst_dac_rdy: got %b want 0", dac_rdy); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    tests++; if (underflow_cnt !== 16'h0) begin fails++; $display("FAIL rst_ufcnt: got %h want 0", underflow_cnt); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    tests++; if (streaming !== 1'b0) begin fails++; $display("FAIL rst_streaming: got %b want 0", streaming); end
    rst = 0; #1;
    tests++; if (dac_rdy !== 1'b1) begin fails++; $display("FAIL post_rst_dac_rdy: got %b want 1", dac_rdy); end
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL post_rst_tvalid: got %b want 1", m_tvalid); end
  endtask

  task automatic test_prime_stream(input logic [31:0] a, input logic [31:0] b, input logic [15:0] uf_exp);
    m_tready = 1; batch_valid = 1; batch_in = a; step();
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL prime_idle_tdata: got %h want 0", m_tdata); end
    batch_in = b; step();
    batch_valid = 0;
    tests++; if (streaming !== 1'b0) begin fails++; $display("FAIL prime_not_yet: got %b want 0", streaming); end
    step();
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL prime_streaming: got %b want 1", streaming); end
    tests++; if (m_tdata !== a) begin fails++; $display("FAIL prime_first: got %h want %h", m_tdata, a); end
    step();
    tests++; if (m_tdata !== b) begin fails++; $display("FAIL prime_second: got %h want %h", m_tdata, b); end
    step();
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL prime_uf_tdata: got %h want 0", m_tdata); end
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL prime_uf_state: got %b want 1", streaming); end
    step();
    tests++; if (streaming !== 1'b0) begin fails++; $display("FAIL prime_back_idle: got %b want 0", streaming); end
    tests++; if (underflow_cnt !== uf_exp) begin fails++; $display("FAIL prime_ufcnt: got %h want %h", underflow_cnt, uf_exp); end
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL prime_tvalid: got %b want 1", m_tvalid); end
  endtask

  task automatic test_backpressure();
    m_tready = 0;
    for (int i = 0; i < 9; i++) begin
      batch_in = 32'hD000_0000 + i; batch_valid = 1;
      tests++; if (dac_rdy !== (i < 8)) begin fails++; $display("FAIL bp_dac_rdy[%0d]: got %b want %b", i, dac_rdy, i < 8); end
      if (i == 8) begin
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_overflow_early: got %b want 0", overflow); end
      end
      if (i >= 3) begin
        tests++; if (m_tdata !== 32'hD000_0000) begin fails++; $display("FAIL bp_hold[%0d]: got %h want d0000000", i, m_tdata); end
      end
      step();
    end
    batch_valid = 0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL bp_streaming: got %b want 1", streaming); end
    m_tready = 1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (m_tdata !== 32'hD000_0000 + i) begin fails++; $display("FAIL bp_drain[%0d]: got %h want %h", i, m_tdata, 32'hD000_0000 + i); end
      step();
    end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL bp_dropped: got %h want 0", m_tdata); end
    step();
    tests++; if (underflow_cnt !== 16'd2) begin fails++; $display("FAIL bp_ufcnt: got %h want 2", underflow_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    m_tready = 0; batch_valid = 1;
    for (int i = 0; i < 3; i++) begin
      batch_in = 32'hE000_0000 + i; q.push_back(batch_in); step();
    end
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL b2b_streaming: got %b want 1", streaming); end
    m_tready = 1;
    for (int i = 0; i < 20; i++) begin
      batch_in = 32'hF000_0000 + i;
      tests++; if (m_tdata !== q[0]) begin fails++; $display("FAIL b2b_order[%0d]: got %h want %h", i, m_tdata, q[0]); end
      q.push_back(batch_in); void'(q.pop_front());
      step();
    end
    batch_valid = 0;
    tests++; if (underflow_cnt !== 16'd2) begin fails++; $display("FAIL b2b_no_uf: got %h want 2", underflow_cnt); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (m_tdata !== q[i]) begin fails++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, m_tdata, q[i]); end
      step();
    end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL b2b_empty: got %h want 0", m_tdata); end
    step();
    tests++; if (underflow_cnt !== 16'd3) begin fails++; $display("FAIL b2b_ufcnt: got %h want 3", underflow_cnt); end
  endtask

  task automatic test_reset_midstream();
    m_tready = 0; batch_valid = 1;
    for (int i = 0; i < 4; i++) begin
      batch_in = 32'h1000_0000 + i; step();
    end
    batch_valid = 0;
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL mrst_pre_stream: got %b want 1", streaming); end
    rst = 1; #1;
    tests++; if (dac_rdy !== 1'b0) begin fails++; $display("FAIL mrst_dac_rdy: got %b want 0", dac_rdy); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL mrst_tvalid: got %b want 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL mrst_tdata: got %h want 0", m_tdata); end
    step();
    tests++; if (streaming !== 1'b0) begin fails++; $display("FAIL mrst_state: got %b want 0", streaming); end
    tests++; if (underflow_cnt !== 16'h0) begin fails++; $display("FAIL mrst_ufcnt: got %h want 0", underflow_cnt); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mrst_overflow: got %b want 0", overflow); end
    rst = 0; #1;
    tests++; if (dac_rdy !== 1'b1) begin fails++; $display("FAIL mrst_release_rdy: got %b want 1", dac_rdy); end
    test_prime_stream(32'h2000_00A0, 32'h2000_00B0, 16'd1);
  endtask

  task automatic test_flush();
    m_tready = 0; batch_valid = 1;
    for (int i = 0; i < 5; i++) begin
      batch_in = 32'h3000_0000 + i; step();
    end
    tests++; if (streaming !== 1'b1) begin fails++; $display("FAIL flush_pre_stream: got %b want 1", streaming); end
    tests++; if (m_tdata !== 32'h3000_0000) begin fails++; $display("FAIL flush_pre_head: got %h want 30000000", m_tdata); end
    flush = 1; batch_in = 32'hBAD0_BAD0; #1;
    tests++; if (dac_rdy !== 1'b0) begin fails++; $display("FAIL flush_dac_rdy: got %b want 0", dac_rdy); end
    step();
    flush = 0; batch_valid = 0; #1;
    tests++; if (streaming !== 1'b0) begin fails++; $display("FAIL flush_state: got %b want 0", streaming); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL flush_tdata: got %h want 0", m_tdata); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL flush_overflow: got %b want 0", overflow); end
    tests++; if (underflow_cnt !== 16'd1) begin fails++; $display("FAIL flush_ufcnt: got %h want 1", underflow_cnt); end
    test_prime_stream(32'h4000_00A0, 32'h4000_00B0, 16'd2);
  endtask

  task automatic test_saturation();
    logic [16:0] exp;
    force dut.underflow_cnt_d = 16'hFFFC;
    step();
    release dut.underflow_cnt_d;
    #1;
    tests++; if (underflow_cnt !== 16'hFFFC) begin fails++; $display("FAIL sat_preload: got %h want fffc", underflow_cnt); end
    m_tready = 1;
    for (int k = 1; k <= 5; k++) begin
      batch_valid = 1; batch_in = 32'h5000_0000 + k; step(); step();
      batch_valid = 0;
      repeat (4) step();
      exp = 17'hFFFC + 17'(k);
      if (exp > 17'hFFFF) exp = 17'hFFFF;
      tests++; if (underflow_cnt !== exp[15:0]) begin fails++; $display("FAIL sat_cnt[%0d]: got %h want %h", k, underflow_cnt, exp[15:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_prime_stream(32'hA0A0_0001, 32'hB0B0_0002, 16'd1);
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
